video_out_fetch: RTL
====================

Name: video_out_fetch

Overview:
- Downstream consumer of the frame that the video input path stores in RAM.
- Acts as a Wishbone master: reads the stored frame from RAM in fixed bursts of NB_PACK 32-bit words.
- Pushes each word into the output-side FIFO, which feeds the display/video-out stage.
- Single clock domain (system clock, 100 MHz); frame base address and enable come from the Wishbone slave register block.

Parameters:
- NB_PACK, 16, words per Wishbone burst; must be at least 2.
- FRAME_WORDS, 76800, 32-bit words per frame (640x480 pixels, 4 pixels per word); must be a multiple of NB_PACK.

Ports:
- clk  in  1  system clock, 100 MHz
- nRST  in  1  asynchronous active-low reset
- wb_reg_data  in  32  frame base address in RAM (byte address; bits [1:0] are ignored and forced to 0)
- wb_reg_ctr  in  32  control; bit 0 = fetch enable, other bits ignored
- space_available  in  1  FIFO has at least NB_PACK free entries
- w_e  out  1  FIFO write strobe, 1 cycle per word
- data_out  out  32  word written to the FIFO
- new_frame  out  1  1-cycle pulse when a new frame fetch starts (used by the downstream stage to resync)
- interrupt  out  1  1-cycle pulse when the last word of a frame is written to the FIFO
- p_wb_STB_O  out  1  Wishbone strobe
- p_wb_CYC_O  out  1  Wishbone cycle
- p_wb_LOCK_O  out  1  Wishbone lock; equals CYC
- p_wb_SEL_O  out  4  byte select; 4'hF whenever STB=1, otherwise 0
- p_wb_WE_O  out  1  always 0 (read-only master)
- p_wb_ADR_O  out  32  read address
- p_wb_ACK_I  in  1  Wishbone acknowledge
- p_wb_DAT_I  in  32  Wishbone read data

Behaviour:
- Reset (nRST low, asynchronous):
  - All outputs go to 0 immediately.
  - State becomes IDLE; address and counters are cleared.
- All outputs are registered.
- State IDLE:
  - CYC, STB and LOCK are 0.
  - When wb_reg_ctr[0]=1: latch base = {wb_reg_data[31:2],2'b00}, set word_cnt=0, pulse new_frame for 1 cycle, go to WAIT_SPACE.
- State WAIT_SPACE:
  - If wb_reg_ctr[0]=0: go to IDLE.
  - Else if space_available=1: next cycle CYC=STB=LOCK=1, ADR=base+4*word_cnt, burst_cnt=0, go to BURST.
  - Else: stay.
- State BURST:
  - STB stays high until NB_PACK ACKs have been received.
  - On each cycle with STB & ACK:
    - Capture DAT_I.
    - Next cycle: w_e=1 and data_out=captured word (FIFO-write latency is 1 cycle after ACK).
    - ADR += 4 (32-bit wrap, modulo 2^32).
    - word_cnt += 1; burst_cnt += 1.
  - On the NB_PACK-th ACK: CYC, STB and LOCK drop to 0 in the next cycle; go to END_CHECK.
  - ACK seen while STB=0 is ignored.
  - Wait states (ACK=0) hold ADR and STB unchanged; there is no timeout.
- State END_CHECK (1 cycle; this is the cycle carrying the last w_e of the burst):
  - If word_cnt==FRAME_WORDS:
    - interrupt=1 in this same cycle.
    - If wb_reg_ctr[0]=1: relatch base from wb_reg_data, set word_cnt=0, pulse new_frame next cycle, go to WAIT_SPACE.
    - Else: go to IDLE.
  - Else if wb_reg_ctr[0]=0: go to IDLE (frame abandoned; next enable restarts at word 0).
  - Else: go to WAIT_SPACE.
- Enable cleared mid-burst: the burst always completes, so the FIFO only ever receives whole bursts. The block stops at END_CHECK.
- Base address changed mid-frame: has no effect until the next frame start.
- space_available is sampled only in WAIT_SPACE. The FIFO must therefore guarantee NB_PACK free entries once it reports space.
- Counter width: word_cnt is $clog2(FRAME_WORDS+1) bits; burst_cnt is $clog2(NB_PACK+1) bits.

Decomposition:
- Shared package video_pkg holds:
  - the state enum {IDLE, WAIT_SPACE, BURST, END_CHECK};
  - FRAME_WORDS_DEFAULT;
  - CTR_ENABLE_BIT=0;
  - WB_SEL_ALL=4'hF.
- Flat single module; no sub-module needed. The address/counter logic is a few registers and stays in the FSM body.

Test Plan (bench NB_PACK=4, FRAME_WORDS=8, ACK slave with programmable wait states):
1. wb_reg_data=32'h0000_1003, enable=1, space_available=1, zero-wait ACK -> new_frame pulses once; ADR sequence 0x1000,0x1004,...,0x101C in 2 bursts of 4; 8 w_e pulses with data matching RAM model; interrupt on 8th w_e; then a new frame starts at 0x1000.
2. space_available=0 for 20 cycles after enable -> CYC stays 0 and no w_e; assert space_available -> burst starts 1 cycle later.
3. Slave inserts 3 wait states per ACK -> STB and ADR held during waits; exactly 4 w_e per burst; each w_e 1 cycle after its ACK.
4. Clear enable after 2nd ACK of burst 1 -> ACKs 3 and 4 still fetched (4 w_e total), no interrupt, state returns to IDLE; re-enable -> ADR restarts at base.
5. nRST asserted during BURST with STB=1 -> CYC, STB, w_e and interrupt are 0 in the same cycle; after release and enable, first ADR equals base.
6. Change wb_reg_data to 0x2000 mid-frame with enable held -> current frame finishes at the old base; next frame ADR starts at 0x2000.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the video output fetch path: FSM states, default
// frame geometry and Wishbone/control register field constants.
package video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST,
    END_CHECK
  } state_t;

  localparam int unsigned FRAME_WORDS_DEFAULT = 76800;
  localparam int unsigned CTR_ENABLE_BIT      = 0;
  localparam logic [3:0]  WB_SEL_ALL          = 4'hF;

endpackage

// File: rtl/video_out_fetch.sv
// Wishbone read master that streams a stored frame from RAM into the video-out
// FIFO in fixed NB_PACK-word bursts, pulsing new_frame/interrupt at frame edges.
module video_out_fetch
  import video_pkg::*;
#(
  parameter int unsigned NB_PACK     = 16,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] wb_reg_data,
  input  logic [31:0] wb_reg_ctr,
  input  logic        space_available,
  output logic        w_e,
  output logic [31:0] data_out,
  output logic        new_frame,
  output logic        interrupt,
  output logic        p_wb_STB_O,
  output logic        p_wb_CYC_O,
  output logic        p_wb_LOCK_O,
  output logic [3:0]  p_wb_SEL_O,
  output logic        p_wb_WE_O,
  output logic [31:0] p_wb_ADR_O,
  input  logic        p_wb_ACK_I,
  input  logic [31:0] p_wb_DAT_I
);

  localparam int unsigned CW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BW = $clog2(NB_PACK + 1);

  state_t        r_state,     w_state_nxt;
  logic [31:0]   r_base,      w_base_nxt;
  logic [31:0]   r_adr,       w_adr_nxt;
  logic [31:0]   r_data,      w_data_nxt;
  logic [CW-1:0] r_word_cnt,  w_word_cnt_nxt;
  logic [BW-1:0] r_burst_cnt, w_burst_cnt_nxt;
  logic          r_cyc,       w_cyc_nxt;
  logic          r_we,        w_we_nxt;
  logic          r_nf,        w_nf_nxt;
  logic          r_int,       w_int_nxt;

  logic        w_en;
  logic        w_ack;
  logic        w_last_beat;
  logic        w_frame_done;
  logic        w_frame_last_word;
  logic [31:0] w_frame_base;
  logic        w_unused_bits;

  assign w_en              = wb_reg_ctr[CTR_ENABLE_BIT];
  assign w_ack             = r_cyc & p_wb_ACK_I;
  assign w_last_beat       = (r_burst_cnt == BW'(NB_PACK - 1));
  assign w_frame_done      = (r_word_cnt == CW'(FRAME_WORDS));
  assign w_frame_last_word = (r_word_cnt == CW'(FRAME_WORDS - 1));
  assign w_frame_base      = {wb_reg_data[31:2], 2'b00};
  assign w_unused_bits     = ^{wb_reg_data[1:0], wb_reg_ctr[31:1]};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_adr       <= '0;
      r_data      <= '0;
      r_word_cnt  <= '0;
      r_burst_cnt <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_nf        <= 1'b0;
      r_int       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_base      <= w_base_nxt;
      r_adr       <= w_adr_nxt;
      r_data      <= w_data_nxt;
      r_word_cnt  <= w_word_cnt_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_nf        <= w_nf_nxt;
      r_int       <= w_int_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_base_nxt      = r_base;
    w_adr_nxt       = r_adr;
    w_data_nxt      = r_data;
    w_word_cnt_nxt  = r_word_cnt;
    w_burst_cnt_nxt = r_burst_cnt;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = 1'b0;
    w_nf_nxt        = 1'b0;
    w_int_nxt       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_en) begin
          w_base_nxt     = w_frame_base;
          w_word_cnt_nxt = '0;
          w_nf_nxt       = 1'b1;
          w_state_nxt    = WAIT_SPACE;
        end
      end

      WAIT_SPACE: begin
        if (!w_en) begin
          w_state_nxt = IDLE;
        end else if (space_available) begin
          w_cyc_nxt       = 1'b1;
          w_adr_nxt       = r_base + (32'(r_word_cnt) << 2);
          w_burst_cnt_nxt = '0;
          w_state_nxt     = BURST;
        end
      end

      // Interrupt is raised on the edge that enters END_CHECK so it lines up
      // with the final FIFO write of the frame.
      BURST: begin
        if (w_ack) begin
          w_data_nxt      = p_wb_DAT_I;
          w_we_nxt        = 1'b1;
          w_adr_nxt       = r_adr + 32'd4;
          w_word_cnt_nxt  = r_word_cnt + CW'(1);
          w_burst_cnt_nxt = r_burst_cnt + BW'(1);
          if (w_last_beat) begin
            w_cyc_nxt   = 1'b0;
            w_int_nxt   = w_frame_last_word;
            w_state_nxt = END_CHECK;
          end
        end
      end

      END_CHECK: begin
        if (w_frame_done) begin
          if (w_en) begin
            w_base_nxt     = w_frame_base;
            w_word_cnt_nxt = '0;
            w_nf_nxt       = 1'b1;
            w_state_nxt    = WAIT_SPACE;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (!w_en) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT_SPACE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // STB and LOCK track CYC: a burst never pauses the strobe mid-cycle.
  assign p_wb_CYC_O  = r_cyc;
  assign p_wb_STB_O  = r_cyc;
  assign p_wb_LOCK_O = r_cyc;
  assign p_wb_SEL_O  = r_cyc ? WB_SEL_ALL : '0;
  assign p_wb_WE_O   = 1'b0;
  assign p_wb_ADR_O  = r_adr;
  assign w_e         = r_we;
  assign data_out    = r_data;
  assign new_frame   = r_nf;
  assign interrupt   = r_int;

endmodule
